// File: rtl/rv32_fetch_pkg.sv
// Shared RV32 pipeline constants used by fetch and decode.
package rv32_fetch_pkg;

    localparam logic [31:0] RV32_INSTR_NOP  = 32'h0000_0013;
    localparam logic [31:0] RV32_ALIGN_MASK = 32'h0000_0003;
    localparam logic [31:0] RV32_INSTR_SIZE = 32'd4;

    function automatic logic rv32_is_aligned(input logic [31:0] addr);
        return (addr & RV32_ALIGN_MASK) == 32'h0;
    endfunction

endpackage

// File: rtl/rv32_fetch_if.sv
// Instruction-memory read channel: fetch is the master, memory the slave.
interface rv32_fetch_if;
    logic        mem_read_out;
    logic [31:0] mem_address_out;
    logic        mem_ready_in;
    logic [31:0] mem_read_value_in;

    modport master (
        output mem_read_out,
        output mem_address_out,
        input  mem_ready_in,
        input  mem_read_value_in
    );

    modport slave (
        input  mem_read_out,
        input  mem_address_out,
        output mem_ready_in,
        output mem_read_value_in
    );
endinterface

// File: rtl/rv32_fetch.sv
// Instruction fetch stage: PC register, memory request and the pc/instr slot
// presented to decode, with stall and redirect handling.
module rv32_fetch
    import rv32_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_pc_in,
    rv32_fetch_if.master mem,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out,
    output logic        misaligned_out
);

    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic        valid_nxt, misaligned_nxt;
    logic [31:0] pc_nxt, instr_nxt;
    logic        accept, aligned;

    // A bubble never stalls: only a live, unconsumed slot blocks the stage.
    assign accept  = !(valid_out && stall_in);
    assign aligned = rv32_is_aligned(fetch_pc);

    assign mem.mem_read_out    = !reset && !branch_taken_in && aligned && accept;
    assign mem.mem_address_out = fetch_pc;

    always_comb begin
        fetch_pc_nxt   = fetch_pc;
        valid_nxt      = valid_out;
        misaligned_nxt = misaligned_out;
        pc_nxt         = pc_out;
        instr_nxt      = instr_out;

        if (branch_taken_in) begin
            // Any read completing this cycle is dropped; the target is fetched next cycle.
            fetch_pc_nxt   = branch_pc_in;
            valid_nxt      = 1'b0;
            misaligned_nxt = 1'b0;
        end else if (accept) begin
            if (!aligned) begin
                pc_nxt         = fetch_pc;
                instr_nxt      = RV32_INSTR_NOP;
                valid_nxt      = 1'b1;
                misaligned_nxt = 1'b1;
            end else if (mem.mem_ready_in) begin
                pc_nxt         = fetch_pc;
                instr_nxt      = mem.mem_read_value_in;
                valid_nxt      = 1'b1;
                misaligned_nxt = 1'b0;
                fetch_pc_nxt   = fetch_pc + RV32_INSTR_SIZE;
            end else begin
                valid_nxt      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc       <= RESET_VECTOR;
            valid_out      <= 1'b0;
            misaligned_out <= 1'b0;
            pc_out         <= 32'h0;
            instr_out      <= RV32_INSTR_NOP;
        end else begin
            fetch_pc       <= fetch_pc_nxt;
            valid_out      <= valid_nxt;
            misaligned_out <= misaligned_nxt;
            pc_out         <= pc_nxt;
            instr_out      <= instr_nxt;
        end
    end

endmodule

// File: tb/tb_rv32_fetch.sv
// Randomized and directed bench for rv32_fetch against a slot-level reference model.
module tb_rv32_fetch;

    localparam logic [31:0] RV     = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] MAGIC  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        branch_taken_in;
    logic [31:0] branch_pc_in;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        misaligned_out;

    rv32_fetch_if bus ();

    rv32_fetch #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .branch_pc_in    (branch_pc_in),
        .mem             (bus.master),
        .valid_out       (valid_out),
        .pc_out          (pc_out),
        .instr_out       (instr_out),
        .misaligned_out  (misaligned_out)
    );

    always #5 clk = ~clk;

    // Memory content: every word is its own address scrambled by a fixed pattern.
    assign bus.mem_read_value_in = bus.mem_address_out ^ MAGIC;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the address the stage wants next, and the slot shown to decode.
    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } slot_t;

    logic [31:0] m_next_addr;
    slot_t       m_slot;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_next_addr = RV;
        m_slot      = '{valid: 1'b0, pc: 32'h0, instr: NOP, mis: 1'b0};
    endtask

    function automatic logic model_blocked(input logic st);
        return m_slot.valid && st;
    endfunction

    task automatic model_step(input logic st, input logic rdy, input logic br, input logic [31:0] bpc);
        if (br) begin
            m_next_addr = bpc;
            m_slot.valid = 1'b0;
            m_slot.mis   = 1'b0;
        end else if (!model_blocked(st)) begin
            if (m_next_addr % 4 != 0)
                m_slot = '{valid: 1'b1, pc: m_next_addr, instr: NOP, mis: 1'b1};
            else if (rdy) begin
                m_slot = '{valid: 1'b1, pc: m_next_addr, instr: m_next_addr ^ MAGIC, mis: 1'b0};
                m_next_addr = m_next_addr + 32'd4;
            end else
                m_slot.valid = 1'b0;
        end
    endtask

    task automatic check_slot();
        check_eq("valid_out", {31'b0, valid_out}, {31'b0, m_slot.valid});
        if (m_slot.valid) begin
            check_eq("pc_out", pc_out, m_slot.pc);
            check_eq("instr_out", instr_out, m_slot.instr);
            check_eq("misaligned_out", {31'b0, misaligned_out}, {31'b0, m_slot.mis});
        end
    endtask

    // One clock: drive at the falling edge, check request, clock, check the slot.
    task automatic cycle(input logic st, input logic rdy, input logic br, input logic [31:0] bpc);
        logic exp_rd;
        stall_in        = st;
        bus.mem_ready_in = rdy;
        branch_taken_in = br;
        branch_pc_in    = bpc;
        #1;
        exp_rd = !br && (m_next_addr % 4 == 0) && !model_blocked(st);
        check_eq("mem_read_out", {31'b0, bus.mem_read_out}, {31'b0, exp_rd});
        check_eq("mem_address_out", bus.mem_address_out, m_next_addr);
        @(posedge clk);
        model_step(st, rdy, br, bpc);
        @(negedge clk);
        check_slot();
    endtask

    // Reset asserted between edges must take effect without a clock.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("rst_valid", {31'b0, valid_out}, 32'h0);
        check_eq("rst_mem_read", {31'b0, bus.mem_read_out}, 32'h0);
        check_eq("rst_address", bus.mem_address_out, RV);
        @(negedge clk);
        check_eq("rst_hold_read", {31'b0, bus.mem_read_out}, 32'h0);
        reset = 1'b0;
    endtask

    initial begin
        reset            = 1'b1;
        stall_in         = 1'b0;
        branch_taken_in  = 1'b0;
        branch_pc_in     = 32'h0;
        bus.mem_ready_in = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_valid", {31'b0, valid_out}, 32'h0);
        check_eq("reset_pc", pc_out, 32'h0);
        check_eq("reset_instr", instr_out, NOP);
        check_eq("reset_mis", {31'b0, misaligned_out}, 32'h0);
        check_eq("reset_mem_read", {31'b0, bus.mem_read_out}, 32'h0);
        reset = 1'b0;

        // Zero-wait streaming: pc 0, 4
        cycle(0, 1, 0, 0);
        check_eq("first_pc", pc_out, 32'h0);
        cycle(0, 1, 0, 0);
        check_eq("second_pc", pc_out, 32'h4);
        // Stall while pc_out=4
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check_eq("stall_hold_pc", pc_out, 32'h4);
        // Memory wait on address 8
        repeat (3) cycle(0, 0, 0, 0);
        check_eq("wait_addr", bus.mem_address_out, 32'h8);
        cycle(0, 1, 0, 0);
        check_eq("after_wait_pc", pc_out, 32'h8);
        check_eq("after_wait_instr", instr_out, 32'h8 ^ MAGIC);
        cycle(0, 1, 0, 0);
        check_eq("pc_12", pc_out, 32'hC);
        // Redirect overriding stall and a completing read
        cycle(1, 1, 1, 32'h100);
        check_eq("redir_bubble", {31'b0, valid_out}, 32'h0);
        cycle(0, 1, 0, 0);
        check_eq("redir_target", pc_out, 32'h100);
        // Misaligned target
        cycle(0, 1, 1, 32'h102);
        repeat (3) cycle(0, 1, 0, 0);
        check_eq("mis_flag", {31'b0, misaligned_out}, 32'h1);
        check_eq("mis_pc", pc_out, 32'h102);
        // Wrap at the top of the address space
        cycle(0, 1, 1, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0);
        check_eq("wrap_top", pc_out, 32'hFFFF_FFFC);
        cycle(0, 1, 0, 0);
        check_eq("wrap_zero", pc_out, 32'h0);
        // Reset during a memory wait
        cycle(0, 0, 0, 0);
        async_reset();
        cycle(0, 1, 0, 0);
        check_eq("post_reset_pc", pc_out, RV);

        for (int i = 0; i < 3000; i++) begin
            logic        st, rdy, br;
            logic [31:0] bpc;
            st  = ($urandom_range(0, 3) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 7))
                0:       bpc = 32'hFFFF_FFF8 + {$urandom_range(0, 7)};
                1:       bpc = {$urandom} | 32'h1;
                default: bpc = {$urandom_range(0, 1023), 2'b00};
            endcase
            if ($urandom_range(0, 499) == 0)
                async_reset();
            else
                cycle(st, rdy, br, bpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rv32_fetch.md
Name: rv32_fetch

Overview:
- Instruction fetch stage: producer of the pc/instr pair consumed by rv32_decode.
- Holds the program counter and issues word reads to instruction memory over a ready handshake.
- Registers each returned word with its PC and presents it to decode with a valid flag.
- Honours a decode-side stall and a branch/jump redirect from the execute stage.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  asynchronous, active-high reset
stall_in  in  1  decode cannot accept a new instruction this cycle
branch_taken_in  in  1  redirect request from execute
branch_pc_in  in  32  redirect target
mem_read_out  out  1  instruction read request
mem_address_out  out  32  read address, equals fetch PC
mem_ready_in  in  1  memory completes the read this cycle
mem_read_value_in  in  32  read data, valid when mem_ready_in=1
valid_out  out  1  pc_out/instr_out hold a live instruction
pc_out  out  32  PC of presented instruction
instr_out  out  32  presented instruction word
misaligned_out  out  1  presented slot is an instruction-address-misaligned fault

Behaviour:
- Reset (async, asserts immediately):
  - fetch_pc = RESET_VECTOR
  - valid_out = 0, pc_out = 0, instr_out = 32'h0000_0013 (NOP), misaligned_out = 0
  - mem_read_out = 0 while reset is high
- Memory protocol:
  - mem_read_out and mem_address_out are combinational from fetch_pc and the output register state.
  - A read completes in a cycle where mem_read_out=1 and mem_ready_in=1.
  - A request may be withdrawn or retargeted before completion; no transaction is committed until completion.
  - At most one read is outstanding. Minimum latency is zero wait states.
- Request gating: mem_read_out = !reset && !branch_taken_in && fetch_pc[1:0]==0 && !(valid_out && stall_in).
- Output registers accept when: !(valid_out && stall_in). A bubble (valid_out=0) never stalls.
- On a completed read with accept:
  - pc_out <= fetch_pc, instr_out <= mem_read_value_in, valid_out <= 1, misaligned_out <= 0
  - fetch_pc <= fetch_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0)
- Accept with no completion (memory wait): valid_out <= 0; fetch_pc unchanged.
- Stall (valid_out=1 and stall_in=1): pc_out, instr_out, valid_out and misaligned_out hold; fetch_pc holds; no request.
- Redirect has highest priority and overrides stall:
  - fetch_pc <= branch_pc_in, valid_out <= 0, misaligned_out <= 0
  - Any read completing in the same cycle is discarded; mem_read_out is 0 that cycle.
  - The first read of the target issues on the next cycle.
- Misaligned fetch_pc (bits [1:0] != 0), when accepting:
  - No memory read is issued.
  - pc_out <= fetch_pc, instr_out <= NOP, misaligned_out <= 1, valid_out <= 1.
  - fetch_pc holds until a redirect; the slot re-presents each accepted cycle.
- Throughput: 1 instruction/cycle with zero-wait memory and no stall.
- Redirect-to-valid latency: 2 cycles (redirect edge, then fetch edge).
- FSM is implicit in three state elements: fetch_pc, valid_out, misaligned_out. There are no further state encodings.

Decomposition:
- Add RV32_INSTR_NOP (32'h0000_0013) to the shared opcode package; decode and fetch both use it.
- Add an RV32_ALIGN_MASK constant to the same package.
- No sub-module: the next-PC mux is simple enough to stay inline.

Test Plan:
- Reset, zero-wait memory, memory returns addr^32'hA5A5_0000 → valid_out rises 1 cycle after release; pc_out sequence 0, 4, 8, 12 with matching instr_out; mem_read_out 0 during reset.
- mem_ready_in low 3 cycles on addr 8 → valid_out=0 for those cycles; mem_address_out stays 8; instr at pc 8 presented the cycle after ready.
- stall_in high 2 cycles while pc_out=4 → pc_out/instr_out hold, mem_read_out=0; resumes with pc_out=8 after release, no instruction lost or duplicated.
- branch_taken_in with branch_pc_in=32'h100, coinciding with mem_ready_in and stall_in → response dropped, valid_out=0 next cycle; next valid has pc_out=32'h100.
- Redirect to 32'h102 → no mem_read_out; valid_out=1, misaligned_out=1, pc_out=32'h102, instr_out=NOP.
- Redirect to 32'hFFFF_FFFC → pc_out FFFF_FFFC then 0000_0000; reset asserted mid-wait → valid_out=0 and next address RESET_VECTOR.
